hazard_sequencer: RTL

//  Pipeline hazard and forwarding sequencer for the 5-stage RV32I core (F/D/X/M/W).

---
 rtl/hazard_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: RAW hazard detection, stall/flush/bubble control and
// registered operand-forwarding flags for a 5-stage RV32I pipeline.
// Optional feature macro: FULL_FORWARD_EN (full M/W->X forwarding; only load-use
// stalls). Without it the flags are tied low and every X/M hazard interlocks.
module hazard_sequencer #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [6:0]       d_opcode,
  input  logic [RA_W-1:0]  d_rs1,
  input  logic [RA_W-1:0]  d_rs2,
  input  logic [RA_W-1:0]  d_rd,
  input  logic             x_branch_taken,
  input  logic             x_jump,
  output logic             stall,
  output logic             flush_fd,
  output logic             bubble_dx,
  output logic             mx_rs1_flag,
  output logic             mx_rs2_flag,
  output logic             wx_rs1_flag,
  output logic             wx_rs2_flag,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // A producer hits a consumer operand only if it really writes a nonzero rd.
  function automatic logic reg_hit(input logic            vld,
                                   input logic            we,
                                   input logic [RA_W-1:0] rd,
                                   input logic            used,
                                   input logic [RA_W-1:0] ra);
    return vld & we & used & (rd != '0) & (rd == ra);
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic            use_rs1, use_rs2, d_we, d_ld;
  // Tracker: _p0 is the X-stage entry, _p1 the M-stage entry. The W entry is
  // not kept because the write-before-read register file covers it.
  logic            trk_vld_p0, trk_we_p0, trk_ld_p0;
  logic [RA_W-1:0] trk_rd_p0;
  logic            trk_vld_p1, trk_we_p1;
  logic [RA_W-1:0] trk_rd_p1;
  logic            haz_x_rs1, haz_x_rs2, haz_m_rs1, haz_m_rs2;
  logic            haz_x, haz_m, load_use, redirect, hold;

  // Decode classification: which operands are read, whether rd is written.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    d_we    = 1'b0;
    d_ld    = 1'b0;
    case (d_opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: d_we = 1'b1;
      OPC_JALR:   begin use_rs1 = 1'b1; d_we = 1'b1; end
      OPC_BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_LOAD:   begin use_rs1 = 1'b1; d_we = 1'b1; d_ld = 1'b1; end
      OPC_STORE:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_OPIMM:  begin use_rs1 = 1'b1; d_we = 1'b1; end
      OPC_OP:     begin use_rs1 = 1'b1; use_rs2 = 1'b1; d_we = 1'b1; end
      default:    ;
    endcase
  end

  assign haz_x_rs1 = d_valid & reg_hit(trk_vld_p0, trk_we_p0, trk_rd_p0, use_rs1, d_rs1);
  assign haz_x_rs2 = d_valid & reg_hit(trk_vld_p0, trk_we_p0, trk_rd_p0, use_rs2, d_rs2);
  assign haz_m_rs1 = d_valid & reg_hit(trk_vld_p1, trk_we_p1, trk_rd_p1, use_rs1, d_rs1);
  assign haz_m_rs2 = d_valid & reg_hit(trk_vld_p1, trk_we_p1, trk_rd_p1, use_rs2, d_rs2);
  assign haz_x     = haz_x_rs1 | haz_x_rs2;
  assign haz_m     = haz_m_rs1 | haz_m_rs2;
  assign load_use  = haz_x & trk_ld_p0;
  assign redirect  = x_branch_taken | x_jump;

`ifdef FULL_FORWARD_EN
  // Everything but a load result can be forwarded in time.
  assign hold = load_use;
`else
  // No forwarding: interlock until the producer has reached W (load_use is
  // already covered by haz_x, kept for clarity of intent).
  assign hold = haz_x | haz_m | load_use;
`endif

  // Same-cycle pipeline control; a redirect squashes the decode slot outright.
  always_comb begin
    stall     = 1'b0;
    flush_fd  = 1'b0;
    bubble_dx = 1'b0;
    if (redirect) begin
      flush_fd  = 1'b1;
      bubble_dx = 1'b1;
    end else if (hold) begin
      stall     = 1'b1;
      bubble_dx = 1'b1;
    end
  end

  // ---- D -> X -> M stage boundary: tracker valid bits (control) ----
  always_ff @(posedge clock) begin
    if (reset) begin
      trk_vld_p0 <= 1'b0;
      trk_vld_p1 <= 1'b0;
    end else begin
      trk_vld_p0 <= d_valid & ~bubble_dx;
      trk_vld_p1 <= trk_vld_p0;
    end
  end

  // Tracker payload advances every cycle; it is qualified by the valid bits.
  always_ff @(posedge clock) begin
    trk_we_p0 <= d_we;
    trk_ld_p0 <= d_ld;
    trk_rd_p0 <= d_rd;
    trk_we_p1 <= trk_we_p0;
    trk_rd_p1 <= trk_rd_p0;
  end

`ifdef FULL_FORWARD_EN
  // Forwarding flags latched as decode enters X; the youngest producer wins.
  always_ff @(posedge clock) begin
    if (reset || bubble_dx) begin
      mx_rs1_flag <= 1'b0;
      mx_rs2_flag <= 1'b0;
      wx_rs1_flag <= 1'b0;
      wx_rs2_flag <= 1'b0;
    end else begin
      mx_rs1_flag <= haz_x_rs1;
      mx_rs2_flag <= haz_x_rs2;
      wx_rs1_flag <= haz_m_rs1 & ~haz_x_rs1;
      wx_rs2_flag <= haz_m_rs2 & ~haz_x_rs2;
    end
  end
`else
  assign mx_rs1_flag = 1'b0;
  assign mx_rs2_flag = 1'b0;
  assign wx_rs1_flag = 1'b0;
  assign wx_rs2_flag = 1'b0;
`endif

  // Saturating performance counters for stall and flush cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall)    stall_cnt <= sat_inc(stall_cnt);
      if (flush_fd) flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule
